seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Iterative shift-and-add multiplier that sits directly upstream of the ripple-carry `adder_n` in the ALU datapath. It supplies `adder_n` with operands once per cycle and shifts the returned sum and carry into a double-width product register. It is the multi-cycle MUL unit behind the single-cycle ALU. The design is a start/done handshake block with fixed latency.

## Interface
- `BITS`, default 32, operand width; product is 2*BITS.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only when not busy.
- `signed_op`  in  1  operands are two's complement (only honoured with `MULT_SIGNED_EN`).
- `A`  in  BITS  multiplicand, sampled with `start`.
- `B`  in  BITS  multiplier, sampled with `start`.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when `P` becomes valid.
- `P`  out  2*BITS  product, held until the next accepted `start`.

## Operation
- States:
  - IDLE
  - RUN (BITS iterations)
  - NEG (signed only)
  - DONE
- Registers:
  - `mcand[BITS-1:0]`
  - `acc[BITS-1:0]`
  - `mplier[BITS-1:0]`
  - iteration counter `cnt`, log2(BITS)+1 bits
  - `neg_res` flag
- Accept: `start`=1 in IDLE or DONE.
  - Load `mcand`=A, `mplier`=B, `acc`=0, `cnt`=0.
  - Enter RUN.
  - `start` while busy is ignored. No queueing, no error.
- RUN, each cycle:
  - One `adder_n #(BITS)` instance computes `acc + (mplier[0] ? mcand : 0)`, cin=0, giving `{cout,sum}`.
  - Next `{acc,mplier}` = `{cout, sum, mplier[BITS-1:1]}`, a right shift by one.
  - `cnt` increments.
  - After the BITS-th iteration, go to NEG if signed handling is active, else DONE.
- NEG:
  - If `neg_res`=1, `{acc,mplier}` = two's complement of itself (bitwise invert, +1 via a 2*BITS `adder_n`). Otherwise hold.
  - Then DONE.
- DONE:
  - `done`=1 for exactly one cycle, `P`={acc,mplier}.
  - Next state is IDLE, or RUN if `start`=1.
- Arithmetic:
  - Unsigned result is exact over 2*BITS bits; no overflow is possible.
  - All additions are carried out by `adder_n` instances; no `+` operator in the datapath.
- Outputs:
  - `P` is driven from the registers.
  - `P` changes during RUN; consumers use it only on or after `done`.

## Timing
- Reset values (async, `rst_n`=0): state=IDLE, `busy`=0, `done`=0, `P`=0, `cnt`=0, `neg_res`=0.
- Reset mid-operation aborts immediately. No `done` is produced for the aborted operation.
- Let edge E0 be the edge that samples `start`.
- `busy`=1 from after E0 until the edge entering DONE.
- Unsigned latency: `done` is high in the cycle after edge E0+BITS, i.e. BITS+1 cycles from `start` to `done`.
- Signed latency (`signed_op`=1 with macro): one extra cycle, BITS+2.
- Back-to-back: `start` held high during DONE begins the next operation with no idle cycle. `done` is still pulsed for the finishing operation.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `MULT_SIGNED_EN` defined:
  - On accept with `signed_op`=1, `mcand`=|A| and `mplier`=|B| (negation via `adder_n`).
  - `neg_res`=A[BITS-1]^B[BITS-1].
  - The NEG state is used.
  - The most-negative operand is handled correctly: its magnitude fits unsigned BITS.
- `MULT_SIGNED_EN` undefined:
  - `signed_op` is ignored; all multiplies are unsigned.
  - NEG state and negation adders are not built.
  - Latency is always BITS+1.

## Test plan
- BITS=32, A=3, B=5, `start` for 1 cycle -> `done` pulse 33 cycles later, P=64'h0F, `busy` high for 32 cycles.
- A=B=32'hFFFFFFFF unsigned -> P=64'hFFFFFFFE_00000001; A=0, B=32'h1234 -> P=0.
- `MULT_SIGNED_EN`, `signed_op`=1:
  - A=-3, B=5 -> P=64'hFFFFFFFF_FFFFFFF1 with `done` 34 cycles after `start`.
  - A=B=32'h80000000 -> P=64'h40000000_00000000.
- `start` pulsed with A=7,B=7 at cycle 10 of an in-flight 3*5 -> result still 15, second request ignored, exactly one `done`.
- `rst_n` low at cycle 12 of an operation -> P=0, `busy`=0, `done`=0 immediately; no `done` after release; new `start` 6*7 -> P=42.
- `start` held high through DONE with new A=2,B=9 -> first `done` gives 15, next `done` 33 cycles later gives 18, no idle gap.

Source files
------------

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/done handshake and operand/product bundle for seq_multiplier
interface seq_multiplier_if #(
  parameter int BITS = 32
);
  logic                start;
  logic                signed_op;
  logic [BITS-1:0]     A;
  logic [BITS-1:0]     B;
  logic                busy;
  logic                done;
  logic [2*BITS-1:0]   P;

  modport master (
    output start, signed_op, A, B,
    input  busy, done, P
  );

  modport slave (
    input  start, signed_op, A, B,
    output busy, done, P
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-and-add multiplier feeding a ripple-carry adder_n
// Optional two's complement support is built when MULT_SIGNED_EN is defined.
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[N];
endmodule

module seq_multiplier #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_multiplier_if.slave mul
);
  localparam int CW = $clog2(BITS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] mcand_q, mcand_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [BITS-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [BITS-1:0] add_b;
  logic [BITS-1:0] add_sum;
  logic            add_cout;

  assign add_b = mplier_q[0] ? mcand_q : '0;

  adder_n #(.N(BITS)) u_add (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MULT_SIGNED_EN
  logic              signed_q, signed_d;
  logic              neg_res_q, neg_res_d;
  logic [BITS-1:0]   neg_a, neg_b;
  logic [2*BITS-1:0] neg_p;
  logic              unused_ca, unused_cb, unused_cp;

  // Magnitudes via invert-plus-one; the most-negative value maps to 2**(BITS-1), which fits unsigned.
  adder_n #(.N(BITS)) u_neg_a (
    .a (~mul.A), .b ('0), .cin (1'b1), .sum (neg_a), .cout (unused_ca)
  );
  adder_n #(.N(BITS)) u_neg_b (
    .a (~mul.B), .b ('0), .cin (1'b1), .sum (neg_b), .cout (unused_cb)
  );
  adder_n #(.N(2*BITS)) u_neg_p (
    .a (~{acc_q, mplier_q}), .b ('0), .cin (1'b1), .sum (neg_p), .cout (unused_cp)
  );
`else
  logic unused_signed_op;
  assign unused_signed_op = mul.signed_op;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
`ifdef MULT_SIGNED_EN
      signed_q  <= 1'b0;
      neg_res_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
`ifdef MULT_SIGNED_EN
      signed_q  <= signed_d;
      neg_res_q <= neg_res_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
`ifdef MULT_SIGNED_EN
    signed_d  = signed_q;
    neg_res_d = neg_res_q;
`endif
    case (state_q)
      RUN: begin
        {acc_d, mplier_d} = {add_cout, add_sum, mplier_q[BITS-1:1]};
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == CW'(BITS - 1)) begin
`ifdef MULT_SIGNED_EN
          state_d = signed_q ? NEG : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      NEG: begin
        if (neg_res_q) begin
          {acc_d, mplier_d} = neg_p;
        end
        state_d = DONE;
      end
`endif
      default: begin
        // IDLE and DONE both accept; a start held through DONE chains with no gap.
        state_d = IDLE;
        if (mul.start) begin
          state_d  = RUN;
          mcand_d  = mul.A;
          mplier_d = mul.B;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MULT_SIGNED_EN
          signed_d  = mul.signed_op;
          neg_res_d = mul.signed_op & (mul.A[BITS-1] ^ mul.B[BITS-1]);
          if (mul.signed_op) begin
            mcand_d  = mul.A[BITS-1] ? neg_a : mul.A;
            mplier_d = mul.B[BITS-1] ? neg_b : mul.B;
          end
`endif
        end
      end
    endcase
  end

  assign mul.busy = (state_q == RUN) || (state_q == NEG);
  assign mul.done = (state_q == DONE);
  assign mul.P    = {acc_q, mplier_q};
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier (BITS=32)
module tb_seq_multiplier;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_multiplier_if #(.BITS(32)) m ();

  seq_multiplier #(.BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where done is seen (or after a timeout, lat=-1).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] p, output int lat, output int bcnt, output logic ovl);
    m.A = a; m.B = b; m.signed_op = sgn; m.start = 1'b1;
    lat = 0; bcnt = 0; ovl = 1'b0; p = '0;
    @(negedge clk);
    m.start = 1'b0;
    lat = 1;
    while (m.done !== 1'b1 && lat < 200) begin
      if (m.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (m.done === 1'b1) begin
      ovl = m.busy;
      p   = m.P;
    end else begin
      lat = -1;
    end
  endtask

  logic [63:0] p;
  int          lat, bcnt, ndone, dcyc;
  logic        ovl;

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    m.start = 1'b0; m.signed_op = 1'b0; m.A = '0; m.B = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(m.busy), 64'd0);
    check("reset_done", 64'(m.done), 64'd0);
    check("reset_P", m.P, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 1'b0, p, lat, bcnt, ovl);
    check("3x5_P", p, 64'h0F);
    check("3x5_latency", 64'(lat), 64'd33);
    check("3x5_busy_cycles", 64'(bcnt), 64'd32);
    check("3x5_busy_done_overlap", 64'(ovl), 64'd0);
    @(negedge clk);
    check("3x5_done_one_cycle", 64'(m.done), 64'd0);
    check("3x5_P_held", m.P, 64'h0F);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat, bcnt, ovl);
    check("max_sq_P", p, 64'hFFFFFFFE_00000001);
    check("max_sq_latency", 64'(lat), 64'd33);
    @(negedge clk);

    run_op(32'd0, 32'h1234, 1'b0, p, lat, bcnt, ovl);
    check("zero_P", p, 64'd0);
    @(negedge clk);

    // Second start mid-flight must be ignored.
    m.A = 32'd3; m.B = 32'd5; m.signed_op = 1'b0; m.start = 1'b1;
    ndone = 0; dcyc = -1; p = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) m.start = 1'b0;
      if (c == 10) begin m.A = 32'd7; m.B = 32'd7; m.start = 1'b1; end
      if (c == 11) m.start = 1'b0;
      if (m.done === 1'b1) begin ndone++; p = m.P; dcyc = c; end
    end
    check("ignore_done_count", 64'(ndone), 64'd1);
    check("ignore_P", p, 64'h0F);
    check("ignore_latency", 64'(dcyc), 64'd33);
    check("ignore_P_held", m.P, 64'h0F);

    // Asynchronous reset mid-operation.
    m.A = 32'd3; m.B = 32'd5; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_P", m.P, 64'd0);
    check("abort_busy", 64'(m.busy), 64'd0);
    check("abort_done", 64'(m.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m.done === 1'b1) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run_op(32'd6, 32'd7, 1'b0, p, lat, bcnt, ovl);
    check("after_abort_P", p, 64'd42);
    @(negedge clk);

    // Back-to-back: start presented during DONE.
    run_op(32'd3, 32'd5, 1'b0, p, lat, bcnt, ovl);
    check("b2b_first_P", p, 64'h0F);
    run_op(32'd2, 32'd9, 1'b0, p, lat, bcnt, ovl);
    check("b2b_second_P", p, 64'd18);
    check("b2b_second_latency", 64'(lat), 64'd33);
    check("b2b_busy_cycles", 64'(bcnt), 64'd32);
    @(negedge clk);

`ifdef MULT_SIGNED_EN
    run_op(32'hFFFFFFFD, 32'd5, 1'b1, p, lat, bcnt, ovl);
    check("signed_m3x5_P", p, 64'hFFFFFFFF_FFFFFFF1);
    check("signed_m3x5_latency", 64'(lat), 64'd34);
    check("signed_busy_cycles", 64'(bcnt), 64'd33);
    check("signed_overlap", 64'(ovl), 64'd0);
    @(negedge clk);
    run_op(32'h80000000, 32'h80000000, 1'b1, p, lat, bcnt, ovl);
    check("signed_minneg_sq_P", p, 64'h40000000_00000000);
    @(negedge clk);
    run_op(32'hFFFFFFFD, 32'd5, 1'b0, p, lat, bcnt, ovl);
    check("unsigned_op_with_macro_P", p, 64'h4_FFFFFFF1);
    check("unsigned_op_with_macro_latency", 64'(lat), 64'd33);
`else
    run_op(32'hFFFFFFFD, 32'd5, 1'b1, p, lat, bcnt, ovl);
    check("signed_op_ignored_P", p, 64'h4_FFFFFFF1);
    check("signed_op_ignored_latency", 64'(lat), 64'd33);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
